alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 The module SHALL have one parameter: FLAG_INIT, 32'h0, value loaded into the flag register at reset.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Ports per requester i in {0,1}: req{i}_valid input 1; req{i}_ready output 1; req{i}_x input 32; req{i}_y input 32; req{i}_op input 3 (ALU op code); req{i}_shamt input 6.
REQ-005 Ports per requester i: rsp{i}_valid output 1; rsp{i}_ready input 1.
REQ-006 Ports: rsp_out output 32 (captured ALU result); rsp_flag output 32 (flag register after the operation).
REQ-007 ALU-side ports: alu_x output 32; alu_y output 32; alu_op output 3; alu_shamt output 6; alu_flag output 32 (current flag register); alu_out input 32; alu_nflag input 32.
REQ-008 Port: flag output 32, continuous copy of the flag register.

Function
REQ-009 States SHALL be IDLE, ISSUE, RESP; encoding is implementation-defined.
REQ-010 IDLE: req{i}_ready SHALL be 1 only for the requester selected by arbitration (REQ-017), 0 otherwise; ISSUE/RESP: both ready SHALL be 0.
REQ-011 Accept occurs when req{i}_valid && req{i}_ready in IDLE; x, y, op, shamt and requester id SHALL be latched; next state ISSUE.
REQ-012 ISSUE (exactly one cycle): alu_x/alu_y/alu_op/alu_shamt SHALL be driven from latched operands; at the closing edge alu_out SHALL be latched into rsp_out and alu_nflag into the flag register; next state RESP.
REQ-013 Outside ISSUE the ALU operand outputs SHALL hold the last latched values (no toggling on idle requests).
REQ-014 RESP: rsp{id}_valid SHALL be 1 for the latched requester only; rsp_out and rsp_flag SHALL be stable; on rsp{id}_ready==1 next state IDLE, otherwise remain in RESP.
REQ-015 Latency: accept edge at cycle N -> rsp_valid high in cycle N+2; minimum initiation interval 3 cycles.
REQ-016 The flag register SHALL change only at the ISSUE closing edge or reset; a requester's operation SHALL see the flags produced by the previously completed operation, regardless of requester.
REQ-017 Arbitration in IDLE: if only one req{i}_valid is 1, that requester SHALL be selected; if both, the rule of REQ-022/REQ-023 applies; if none, no ready is asserted.
REQ-018 Requests withdrawn (valid dropped) before acceptance SHALL be ignored without side effect; valid need not be held but operands are sampled only at the accept edge.
REQ-019 rsp_ready asserted by the non-owning requester SHALL have no effect.

Reset
REQ-020 On rst_n==0, asynchronously: state IDLE, flag register = FLAG_INIT, rsp_out = 0, latched operands = 0, both rsp{i}_valid = 0, round-robin pointer = requester 0; reset mid-ISSUE or mid-RESP SHALL discard the operation with no flag update.
REQ-021 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-022 With macro ALU_SCHED_RR_EN defined: on simultaneous requests, priority SHALL go to the requester not served last (pointer toggles on each accept).
REQ-023 Without ALU_SCHED_RR_EN: requester 0 SHALL always win simultaneous requests (fixed priority); pointer logic absent.

Verification
REQ-024 Single add: req0 x=5, y=7, op=ADD -> rsp0_valid two cycles after accept, rsp_out=12, flag zero bit 0.
REQ-025 Sub to zero: req1 x=9, y=9, op=SUB -> rsp_out=0, zero flag bit set in rsp_flag and flag; next op on req0 sees alu_flag with zero bit set.
REQ-026 Contention: both valid continuously for 4 ops -> with ALU_SCHED_RR_EN grants 0,1,0,1; without, grants 0,0,0,0 and req1 starved.
REQ-027 Backpressure: rsp0_ready held 0 for 5 cycles -> rsp0_valid, rsp_out, flag stable; req1_ready stays 0 throughout.
REQ-028 Reset mid-ISSUE: rst_n low during ISSUE -> no rsp_valid, flag = FLAG_INIT, state IDLE after release.
REQ-029 Overflow: op=ADD x=32'h7FFFFFFF, y=1 -> rsp_out=32'h80000000, overflow flag bit set in rsp_flag.

Source files
------------

// File: rtl/alu_sched.sv
// Two-requester scheduler for a shared external ALU with a common flag register.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_sched #(
  parameter logic [31:0] FLAG_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic [2:0]  req0_op,
  input  logic [5:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic [2:0]  req1_op,
  input  logic [5:0]  req1_shamt,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_out,
  output logic [31:0] rsp_flag,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [2:0]  alu_op,
  output logic [5:0]  alu_shamt,
  output logic [31:0] alu_flag,
  input  logic [31:0] alu_out,
  input  logic [31:0] alu_nflag,
  output logic [31:0] flag
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic [2:0]  op_q, op_d;
  logic [5:0]  shamt_q, shamt_d;
  logic        id_q, id_d;
  logic [31:0] out_q, out_d;
  logic [31:0] flag_q, flag_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic        gnt0, gnt1;
`ifdef ALU_SCHED_RR_EN
  logic        ptr_q, ptr_d;
`endif

  // Grant is combinational from the live valids so the first request after idle is taken at once.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_SCHED_RR_EN
        gnt0 = ~ptr_q;
        gnt1 = ptr_q;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    op_d         = op_q;
    shamt_d      = shamt_q;
    id_d         = id_q;
    out_d        = out_q;
    flag_d       = flag_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
`ifdef ALU_SCHED_RR_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          id_d    = gnt1;
          x_d     = gnt1 ? req1_x     : req0_x;
          y_d     = gnt1 ? req1_y     : req0_y;
          op_d    = gnt1 ? req1_op    : req0_op;
          shamt_d = gnt1 ? req1_shamt : req0_shamt;
          state_d = ISSUE;
`ifdef ALU_SCHED_RR_EN
          // Favour whichever requester was not just served.
          ptr_d   = gnt0;
`endif
        end
      end
      ISSUE: begin
        out_d        = alu_out;
        flag_d       = alu_nflag;
        rsp0_valid_d = ~id_q;
        rsp1_valid_d = id_q;
        state_d      = RESP;
      end
      RESP: begin
        if (id_q ? rsp1_ready : rsp0_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      op_q         <= '0;
      shamt_q      <= '0;
      id_q         <= 1'b0;
      out_q        <= '0;
      flag_q       <= FLAG_INIT;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
`ifdef ALU_SCHED_RR_EN
      ptr_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      op_q         <= op_d;
      shamt_q      <= shamt_d;
      id_q         <= id_d;
      out_q        <= out_d;
      flag_q       <= flag_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
`ifdef ALU_SCHED_RR_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  // Operand outputs follow the latched copy, so they only move on an accept.
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_out    = out_q;
  assign rsp_flag   = flag_q;
  assign flag       = flag_q;
  assign alu_flag   = flag_q;
  assign alu_x      = x_q;
  assign alu_y      = y_q;
  assign alu_op     = op_q;
  assign alu_shamt  = shamt_q;

endmodule

// File: tb/tb_alu_sched.sv
// Randomized and directed bench for alu_sched with a transaction-level reference model
// and a bench-side ALU (flags: bit0 zero, bit1 signed overflow, bit2 carry/borrow).
module tb_alu_sched;

  localparam logic [31:0] FI = 32'hA5A5_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0;
  logic [2:0]  req0_op = 0, req1_op = 0;
  logic [5:0]  req0_shamt = 0, req1_shamt = 0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp_out, rsp_flag, alu_x, alu_y, alu_flag, alu_out, alu_nflag, flag;
  logic [2:0]  alu_op;
  logic [5:0]  alu_shamt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  alu_sched #(.FLAG_INIT(FI)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req0_op(req0_op), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .req1_op(req1_op), .req1_shamt(req1_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_out(rsp_out), .rsp_flag(rsp_flag),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_shamt(alu_shamt), .alu_flag(alu_flag),
    .alu_out(alu_out), .alu_nflag(alu_nflag), .flag(flag)
  );

  always #5 clk = ~clk;

  // Returns {new_flags, result}.
  function automatic logic [63:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] op, input logic [5:0] sh,
                                         input logic [31:0] f);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin w = {1'b0, x} + {1'b0, y}; r = w[31:0]; c = w[32];
                  v = (x[31] == y[31]) && (r[31] != x[31]); end
      3'd1: begin r = x - y; c = (x < y); v = (x[31] != y[31]) && (r[31] != x[31]); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x << sh;
      3'd6: r = x >> sh;
      default: begin w = {1'b0, x} + {1'b0, y} + {32'd0, f[2]}; r = w[31:0]; c = w[32];
                     v = (x[31] == y[31]) && (r[31] != x[31]); end
    endcase
    return {f[31:3], c, v, (r == 32'd0), r};
  endfunction

  always_comb {alu_nflag, alu_out} = alu_fn(alu_x, alu_y, alu_op, alu_shamt, alu_flag);

  // Reference model: one transaction in flight; age 0 = computing, age 1 = response offered.
  bit          m_busy, m_owner, m_last;
  int          m_age;
  logic [31:0] m_x, m_y, m_out, m_flag;
  logic [2:0]  m_op;
  logic [5:0]  m_sh;

  function automatic int pick(input logic v0, input logic v1, input bit last);
    if (v0 && v1) begin
`ifdef ALU_SCHED_RR_EN
      return last ? 0 : 1;
`else
      return 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [63:0] r;
    int g;
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_age = 0;
      m_x = 0; m_y = 0; m_op = 0; m_sh = 0; m_out = 0; m_flag = FI;
    end else if (!m_busy) begin
      g = pick(req0_valid, req1_valid, m_last);
      if (g >= 0) begin
        m_owner = (g == 1);
        m_x  = m_owner ? req1_x : req0_x;
        m_y  = m_owner ? req1_y : req0_y;
        m_op = m_owner ? req1_op : req0_op;
        m_sh = m_owner ? req1_shamt : req0_shamt;
        m_busy = 1; m_age = 0; m_last = m_owner;
      end
    end else if (m_age == 0) begin
      r = alu_fn(m_x, m_y, m_op, m_sh, m_flag);
      m_out = r[31:0];
      m_flag = r[63:32];
      m_age = 1;
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      m_busy = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int g;
      g = m_busy ? -1 : pick(req0_valid, req1_valid, m_last);
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
      chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_busy && m_age == 1 && !m_owner});
      chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_busy && m_age == 1 && m_owner});
      chk("rsp_out", rsp_out, m_out);
      chk("rsp_flag", rsp_flag, m_flag);
      chk("flag", flag, m_flag);
      chk("alu_flag", alu_flag, m_flag);
      chk("alu_x", alu_x, m_x);
      chk("alu_y", alu_y, m_y);
      chk("alu_op", {29'd0, alu_op}, {29'd0, m_op});
      chk("alu_shamt", {26'd0, alu_shamt}, {26'd0, m_sh});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a request and returns one time unit after the accept edge (the compute cycle).
  task automatic issue(input int id, input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] op, input logic [5:0] sh);
    bit ok;
    ok = 0;
    if (id == 0) begin req0_valid = 1; req0_x = x; req0_y = y; req0_op = op; req0_shamt = sh; end
    else begin req1_valid = 1; req1_x = x; req1_y = y; req1_op = op; req1_shamt = sh; end
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if ((id == 0) ? req0_ready : req1_ready) ok = 1;
      @(posedge clk);
    end
    #1;
    if (id == 0) req0_valid = 0; else req1_valid = 0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic respond(input int id);
    if (id == 0) rsp0_ready = 1; else rsp1_ready = 1;
    tick();
    rsp0_ready = 0;
    rsp1_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] got_g;
    bit got;
    #1;
    rst_n = 0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_flag", flag, 32'hA5A5_0004);
    chk("rst_rsp_out", rsp_out, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    rst_n = 1;

    issue(0, 32'd5, 32'd7, 3'd0, 6'd0);
    chk("add_issue_no_rsp", {31'd0, rsp0_valid}, 32'd0);
    tick();
    chk("add_rsp_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("add_out", rsp_out, 32'd12);
    chk("add_flag", rsp_flag, 32'hA5A5_0000);
    respond(0);

    issue(1, 32'd9, 32'd9, 3'd1, 6'd0);
    tick();
    chk("sub_rsp_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("sub_out", rsp_out, 32'd0);
    chk("sub_flag", rsp_flag, 32'hA5A5_0001);
    chk("sub_flag_port", flag, 32'hA5A5_0001);
    respond(1);
    issue(0, 32'd3, 32'd4, 3'd2, 6'd0);
    chk("next_sees_zero", alu_flag, 32'hA5A5_0001);
    tick();
    respond(0);

    issue(0, 32'h7FFF_FFFF, 32'd1, 3'd0, 6'd0);
    tick();
    chk("ovf_out", rsp_out, 32'h8000_0000);
    chk("ovf_flag", rsp_flag, 32'hA5A5_0002);
    respond(0);

    issue(0, 32'd10, 32'd20, 3'd0, 6'd0);
    req1_valid = 1;
    rsp1_ready = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("bp_out", rsp_out, 32'd30);
      chk("bp_flag", flag, 32'hA5A5_0000);
      chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
      tick();
    end
    req1_valid = 0;
    respond(0);

    do_reset();
`ifdef ALU_SCHED_RR_EN
    exp_g = 4'b1010;
`else
    exp_g = 4'b0000;
`endif
    got_g = '0;
    req0_valid = 1; req0_x = 32'd1; req0_y = 32'd1; req0_op = 3'd0;
    req1_valid = 1; req1_x = 32'd2; req1_y = 32'd2; req1_op = 3'd0;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int n = 0; n < 10 && !got; n++) begin
        #1;
        if (req0_ready || req1_ready) begin got_g[k] = req1_ready; got = 1; end
        @(posedge clk);
      end
      if (!got) chk("contention_timeout", 32'd0, 32'd1);
    end
    #1;
    chk("grants", {28'd0, got_g}, {28'd0, exp_g});
    req0_valid = 0; req1_valid = 0;
    tick(); tick(); tick();
    rsp0_ready = 0; rsp1_ready = 0;

    issue(0, 32'd1, 32'd2, 3'd0, 6'd0);
    rst_n = 0;
    #1;
    chk("midrst_flag", flag, 32'hA5A5_0004);
    chk("midrst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    tick(); tick();
    chk("midrst_hold", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    rst_n = 1;
    req1_valid = 1; req1_x = 32'd40; req1_y = 32'd2; req1_op = 3'd0; req1_shamt = 6'd0;
    #1;
    chk("post_rst_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 0;
    chk("post_rst_accept", alu_x, 32'd40);
    tick();
    chk("post_rst_out", rsp_out, 32'd42);
    respond(1);

    for (int c = 0; c < 400; c++) begin
      req0_valid = ($urandom_range(0, 1) == 1);
      req1_valid = ($urandom_range(0, 1) == 1);
      req0_x = $urandom; req1_x = $urandom;
      req0_y = ($urandom_range(0, 3) == 0) ? req0_x : $urandom;
      req1_y = ($urandom_range(0, 3) == 0) ? req1_x : $urandom;
      req0_op = 3'($urandom_range(0, 7)); req1_op = 3'($urandom_range(0, 7));
      req0_shamt = 6'($urandom_range(0, 63)); req1_shamt = 6'($urandom_range(0, 63));
      rsp0_ready = ($urandom_range(0, 4) < 3);
      rsp1_ready = ($urandom_range(0, 4) < 3);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    tick(); tick(); tick(); tick();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
